// File: rtl/soc_bus_pkg.sv
// Shared types and helpers for the SoC bus fabric: state encoding, bus width,
// error read value and the byte-lane swap used on swapped slave windows.
package soc_bus_pkg;

    localparam int unsigned      BUS_W     = 32;
    localparam logic [BUS_W-1:0] ERR_RDATA = 32'h0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_e;

    function automatic logic [BUS_W-1:0] bswap(input logic [BUS_W-1:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/soc_bus_wait_timer.sv
// Saturating wait-cycle counter; expired is raised once LIMIT wait cycles
// have been counted. clear has priority over enable.
module soc_bus_wait_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned       CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] MAX   = CNT_W'(LIMIT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

    always_comb expired = (count >= MAX);

endmodule

// File: rtl/soc_bus_fabric.sv
// Single-master to NUM_SLAVES window fabric: combinational decode, one access
// in flight, wait-state stalling with timeout and unmapped-write error reporting.
module soc_bus_fabric
    import soc_bus_pkg::*;
#(
    parameter int unsigned                NUM_SLAVES = 4,
    parameter int unsigned                DEC_HI     = 31,
    parameter int unsigned                DEC_LO     = 24,
    parameter logic [NUM_SLAVES*8-1:0]    SLV_BASE   = {8'hE4, 8'hE3, 8'hE2, 8'hE1},
    parameter logic [NUM_SLAVES-1:0]      SWAP_MASK  = '1,
    parameter int unsigned                TIMEOUT    = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [BUS_W-1:0]            addr_i,
    input  logic [BUS_W-1:0]            wdata_i,
    input  logic [3:0]                  we_i,
    output logic [BUS_W-1:0]            rdata_o,
    output logic                        stall_o,
    output logic                        err_o,
    output logic [NUM_SLAVES-1:0]       slv_sel_o,
    output logic                        slv_wr_o,
    output logic [BUS_W-1:0]            slv_wdata_o,
    input  logic [NUM_SLAVES*BUS_W-1:0] slv_rdata_i,
    input  logic [NUM_SLAVES-1:0]       slv_ready_i
);

    localparam int unsigned DEC_W = DEC_HI - DEC_LO + 1;
    localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sel_q, dec_idx, cur_idx;
    logic             valid_q, valid_d;
    logic             uerr_q, uerr_d;
    logic             hit, issue, can_issue;
    logic             t_clear, t_en, expired;
    logic [BUS_W-1:0] slv_rd [NUM_SLAVES];
    logic [BUS_W-1:0] rd_word;
    logic             unused_addr;

    // Address bits outside the decoded field are don't-care for the fabric.
    always_comb unused_addr = ^addr_i;

    always_comb begin
        hit     = 1'b0;
        dec_idx = '0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (!hit && (addr_i[DEC_HI:DEC_LO] == SLV_BASE[k*8 +: DEC_W])) begin
                hit     = 1'b1;
                dec_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            slv_rd[k] = slv_rdata_i[k*BUS_W +: BUS_W];
        end
        rd_word = SWAP_MASK[sel_q] ? bswap(slv_rd[sel_q]) : slv_rd[sel_q];
    end

    soc_bus_wait_timer #(
        .LIMIT(TIMEOUT)
    ) u_timer (
        .clk    (clk_i),
        .rst    (rst_i),
        .clear  (t_clear),
        .enable (t_en),
        .expired(expired)
    );

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        uerr_d    = 1'b0;
        issue     = 1'b0;
        can_issue = 1'b0;
        t_clear   = 1'b1;
        t_en      = 1'b0;
        stall_o   = 1'b0;
        err_o     = uerr_q;
        rdata_o   = ERR_RDATA;
        slv_sel_o = '0;

        case (state_q)
            IDLE: can_issue = 1'b1;
            ACCESS, WAIT: begin
                // Ready is checked before the timeout so a late ready still completes cleanly.
                if (slv_ready_i[sel_q]) begin
                    rdata_o   = valid_q ? rd_word : ERR_RDATA;
                    state_d   = IDLE;
                    valid_d   = 1'b0;
                    can_issue = 1'b1;
                end else if ((state_q == WAIT) && expired) begin
                    err_o   = 1'b1;
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else begin
                    stall_o          = 1'b1;
                    state_d          = WAIT;
                    t_clear          = 1'b0;
                    t_en             = 1'b1;
                    slv_sel_o[sel_q] = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        if (can_issue && !rst_i) begin
            if (hit) begin
                issue              = 1'b1;
                state_d            = ACCESS;
                valid_d            = 1'b1;
                slv_sel_o          = '0;
                slv_sel_o[dec_idx] = 1'b1;
            end else if (|we_i) begin
                uerr_d = 1'b1;
            end
        end

        cur_idx     = issue ? dec_idx : sel_q;
        slv_wdata_o = SWAP_MASK[cur_idx] ? bswap(wdata_i) : wdata_i;
        slv_wr_o    = (|we_i) && (|slv_sel_o);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            valid_q <= 1'b0;
            uerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            uerr_q  <= uerr_d;
            if (issue) begin
                sel_q <= dec_idx;
            end
        end
    end

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Scoreboard bench for soc_bus_fabric: each issued access pushes its expected
// response; the response cycle (first cycle with stall low) pops and compares.
module tb_soc_bus_fabric;

    localparam int               NS   = 4;
    localparam int               TMO  = 16;
    localparam logic [NS*8-1:0]  BASE = {8'hE2, 8'hE3, 8'hE2, 8'hE1};
    localparam logic [NS-1:0]    MASK = 4'b1011;

    logic           clk_i, rst_i;
    logic [31:0]    addr_i, wdata_i, rdata_o, slv_wdata_o;
    logic [3:0]     we_i, slv_sel_o, slv_ready_i;
    logic           stall_o, err_o, slv_wr_o;
    logic [NS*32-1:0] slv_rdata_i;

    soc_bus_fabric #(
        .NUM_SLAVES(NS),
        .DEC_HI    (31),
        .DEC_LO    (24),
        .SLV_BASE  (BASE),
        .SWAP_MASK (MASK),
        .TIMEOUT   (TMO)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .we_i       (we_i),
        .rdata_o    (rdata_o),
        .stall_o    (stall_o),
        .err_o      (err_o),
        .slv_sel_o  (slv_sel_o),
        .slv_wr_o   (slv_wr_o),
        .slv_wdata_o(slv_wdata_o),
        .slv_rdata_i(slv_rdata_i),
        .slv_ready_i(slv_ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          stalls;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] sdata [NS];
    logic [3:0]  mask_v;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          pending  = 0;
    int          cur_slave, cur_dly, resp_cycle, stall_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] tb_swap(input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(3-i) +: 8];
        return r;
    endfunction

    // slave: -2 no access, -1 unmapped write, 0..3 expected winning slave.
    // dly: cycles the target slave holds ready low after the issue cycle.
    task automatic step(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                        input int slave, input int dly);
        exp_t        e;
        logic [31:0] want;
        addr_i      = a;
        we_i        = we;
        wdata_i     = wd;
        slv_ready_i = 4'hF;
        if (pending && cur_slave >= 0) slv_ready_i[cur_slave] = (resp_cycle >= cur_dly);
        @(negedge clk_i);
        if (pending) begin
            if (!stall_o) begin
                e = exp_q.pop_front();
                check("rdata", rdata_o, e.rdata);
                check("err", 32'(err_o), 32'(e.err));
                check("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
                pending = 0;
            end else begin
                stall_cnt++;
                if (stall_cnt > 3 * TMO) begin
                    e = exp_q.pop_front();
                    check("stall_bound", 32'(stall_cnt), 32'(e.stalls));
                    pending = 0;
                end
            end
        end else begin
            check("idle_rdata", rdata_o, 32'h0);
            check("idle_err", 32'(err_o), 32'h0);
            check("idle_stall", 32'(stall_o), 32'h0);
        end
        if (slave >= -1) begin
            check("issue_sel", 32'(slv_sel_o), (slave >= 0) ? 32'(1 << slave) : 32'h0);
            check("issue_wr", 32'(slv_wr_o), 32'((|we) && (slave >= 0)));
            if (slave >= 0 && (|we)) begin
                want = mask_v[slave] ? tb_swap(wd) : wd;
                check("issue_wdata", slv_wdata_o, want);
            end
            if (slave < 0)        e = '{32'h0, 1'b1, 0};
            else if (dly > TMO)   e = '{32'h0, 1'b1, TMO};
            else                  e = '{mask_v[slave] ? tb_swap(sdata[slave]) : sdata[slave], 1'b0, dly};
            exp_q.push_back(e);
            pending    = 1;
            cur_slave  = slave;
            cur_dly    = dly;
            resp_cycle = 0;
            stall_cnt  = 0;
        end else begin
            if (!pending) check("no_sel", 32'(slv_sel_o), 32'h0);
            if (pending) resp_cycle++;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        step(32'h0000_0000, 4'h0, 32'h0, -2, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && pending; i++) idle();
        check("drain", 32'(pending), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mask_v      = MASK;
        sdata[0]    = 32'h1122_3344;
        sdata[1]    = 32'h5566_7788;
        sdata[2]    = 32'h99AA_BBCC;
        sdata[3]    = 32'hDEAD_BEEF;
        slv_rdata_i = {sdata[3], sdata[2], sdata[1], sdata[0]};
        slv_ready_i = 4'hF;
        rst_i       = 1'b1;
        addr_i      = 32'hE100_0000;
        wdata_i     = 32'h0;
        we_i        = 4'h0;
        #2;
        check("rst_sel", 32'(slv_sel_o), 32'h0);
        check("rst_wr", 32'(slv_wr_o), 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_stall", 32'(stall_o), 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // First access right after reset, slave 0 swapped read.
        step(32'hE100_0010, 4'h0, 32'h0, 0, 0);
        idle();
        // Three wait cycles on slave 1.
        step(32'hE200_0020, 4'h0, 32'h0, 1, 3);
        drain();
        // Slave 2 never ready: timeout error.
        step(32'hE300_0000, 4'h0, 32'h0, 2, 1000);
        drain();
        idle();
        // Unmapped write, then silently ignored unmapped read.
        step(32'hE700_0000, 4'hF, 32'h1234_5678, -1, 0);
        drain();
        step(32'hE700_0000, 4'h0, 32'h0, -2, 0);
        idle();
        // Overlapping window: slave 1 wins over slave 3.
        step(32'hE200_0000, 4'h0, 32'h0, 1, 0);
        drain();
        // Back-to-back reads with no bubble.
        step(32'hE100_0004, 4'h0, 32'h0, 0, 0);
        step(32'hE300_0008, 4'h0, 32'h0, 2, 0);
        step(32'hE100_0000, 4'h0, 32'h0, 0, 1);
        drain();
        // Writes through swapped and unswapped windows.
        step(32'hE200_0000, 4'hF, 32'hAABB_CCDD, 1, 0);
        step(32'hE300_0000, 4'h3, 32'h0102_0304, 2, 2);
        drain();
        // Timeout boundary: ready on the last allowed cycle wins.
        step(32'hE100_0000, 4'h0, 32'h0, 0, TMO);
        drain();
        step(32'hE200_0000, 4'h0, 32'h0, 1, TMO - 1);
        drain();
        idle();

        // Reset in the middle of a wait.
        step(32'hE300_0000, 4'h0, 32'h0, 2, 1000);
        repeat (6) idle();
        rst_i = 1'b1;
        #1;
        check("midrst_rdata", rdata_o, 32'h0);
        check("midrst_stall", 32'(stall_o), 32'h0);
        check("midrst_err", 32'(err_o), 32'h0);
        check("midrst_sel", 32'(slv_sel_o), 32'h0);
        exp_q.delete();
        pending = 0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        step(32'hE100_0000, 4'h0, 32'h0, 0, 0);
        drain();
        idle();

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/soc_bus_fabric.md
SOC_BUS_FABRIC -- requirements
Module: soc_bus_fabric

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, number of slave windows (1..8).
REQ-002 SHALL have parameter DEC_HI, default 31, MSB of the decoded address field.
REQ-003 SHALL have parameter DEC_LO, default 24, LSB of the decoded address field (DEC_HI-DEC_LO+1 <= 8).
REQ-004 SHALL have parameter SLV_BASE, default {8'hE4,8'hE3,8'hE2,8'hE1}, packed NUM_SLAVES*8 decode values, slave 0 in the LSBs.
REQ-005 SHALL have parameter SWAP_MASK, default all-ones, with bit k=1 byte-swapping slave k's read and write data.
REQ-006 SHALL have parameter TIMEOUT, default 16, maximum wait cycles before an error termination (>=1).
REQ-007 SHALL have port clk_i, input, 1, the single clock; one clock; reset is asynchronous and active-high.
REQ-008 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port addr_i, input, 32, master address, held stable while stall_o=1.
REQ-010 SHALL have port wdata_i, input, 32, master write data.
REQ-011 SHALL have port we_i, input, 4, master byte write enables.
REQ-012 SHALL have port rdata_o, output, 32, read data returned to the master.
REQ-013 SHALL have port stall_o, output, 1, stalls the master.
REQ-014 SHALL have port err_o, output, 1, one-cycle pulse on an unmapped access or a timeout.
REQ-015 SHALL have port slv_sel_o, output, NUM_SLAVES, one-hot slave select.
REQ-016 SHALL have port slv_wr_o, output, 1, write strobe, equal to |we_i qualified by any select.
REQ-017 SHALL have port slv_wdata_o, output, 32, write data, swapped per SWAP_MASK of the selected slave.
REQ-018 SHALL have port slv_rdata_i, input, NUM_SLAVES*32, flattened slave read data, slave 0 in the LSBs.
REQ-019 SHALL have port slv_ready_i, input, NUM_SLAVES, slave data valid / access complete.

Function
REQ-020 Decode SHALL be combinational: slave k matches when addr_i[DEC_HI:DEC_LO]==SLV_BASE[k]; on multiple matches the lowest k wins.
REQ-021 An access SHALL be defined as a cycle in state IDLE where addr_i lies in the window set, or any cycle with we_i!=0.
REQ-022 States SHALL be IDLE, ACCESS and WAIT.
REQ-023 IDLE with a matched access SHALL register the index in sel_q, set valid_q and go to ACCESS; slv_sel_o[k] SHALL assert in the issue cycle.
REQ-024 ACCESS with slv_ready_i[sel_q]=1 SHALL make rdata_o the (optionally swapped) slv_rdata_i slice, stall_o=0, and return to IDLE, or re-enter ACCESS on a back-to-back match.
REQ-025 ACCESS with slv_ready_i[sel_q]=0 SHALL assert stall_o and go to WAIT; slv_sel_o SHALL stay held on sel_q, and the wait counter SHALL start at 1.
REQ-026 WAIT SHALL keep stall_o=1 and increment the counter each cycle until ready.
REQ-027 On ready in WAIT, the fabric SHALL behave as REQ-024 in that cycle.
REQ-028 When the counter reaches TIMEOUT without ready, the fabric SHALL drive rdata_o=32'h0, stall_o=0 and err_o=1 for exactly one cycle, then go to IDLE.
REQ-029 Ready and timeout in the same cycle: ready SHALL win, with no error.
REQ-030 An unmapped access (no match, we_i!=0 or DEC field outside every window) SHALL assert no select, and on the next cycle give rdata_o=0, err_o=1 and no stall.
REQ-031 Non-window reads with we_i=0 SHALL be ignored silently; they are the boot/RAM path owned by the top level.
REQ-032 With valid_q=0, rdata_o SHALL be 0.
REQ-033 The wait counter width SHALL be $clog2(TIMEOUT+1) bits, SHALL saturate, and SHALL clear on every entry to IDLE.

Reset
REQ-034 Asserting rst_i SHALL immediately force IDLE, valid_q=0, counter=0, err_o=0, stall_o=0, rdata_o=0 and slv_sel_o=0, including when asserted mid-WAIT.
REQ-035 After reset release, the first access SHALL be accepted on the first rising edge.

Structure
REQ-036 Package soc_bus_pkg SHALL hold the state enum, the BUS_W=32 constant, the ERR_RDATA=32'h0 constant and a byte-swap function.
REQ-037 One sub-module, soc_bus_wait_timer (the counter plus timeout compare, with clear/enable/expired), SHALL be instantiated; decode and the read mux SHALL stay inline.

Verification
REQ-038 Read 0xE1000010 with slave 0 ready, returning 0x11223344 -> rdata_o=0x44332211 one cycle later, stall_o=0.
REQ-039 Slave 1 holds ready low for 3 cycles -> stall_o high for exactly 3 cycles, data returned on cycle 4, err_o=0.
REQ-040 Slave 2 never ready, TIMEOUT=16 -> stall for 16 cycles, then err_o single pulse with rdata_o=0, next state IDLE.
REQ-041 Write to 0xE7000000, we_i=4'hF -> slv_sel_o=0, slv_wr_o=0, err_o pulse on the next cycle.
REQ-042 rst_i asserted during cycle 5 of WAIT -> all outputs 0 within the same cycle; the next access completes normally.
REQ-043 Overlapping SLV_BASE entries for slaves 1 and 3 -> slave 1 selected only; back-to-back reads to slaves 0 then 2 -> no bubble, correct data each cycle.
